// File: rtl/etroc2_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module  : etroc2_sync_pkg
// Brief   : Shared constants and FSM encoding for the ETROC2 link supervisor.
// Revision: 1.0 - initial release
// ============================================================================
package etroc2_sync_pkg;

  localparam int CNT_W = 16;
  localparam int ATT_W = 8;

  typedef logic [2:0] syncState_t;

  localparam syncState_t ST_IDLE      = 3'd0;
  localparam syncState_t ST_RESET     = 3'd1;
  localparam syncState_t ST_WAIT_LOCK = 3'd2;
  localparam syncState_t ST_SETTLE    = 3'd3;
  localparam syncState_t ST_CLEAR     = 3'd4;
  localparam syncState_t ST_RETRY     = 3'd5;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin pick of the lowest request at or above ptr.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grantIdx,
  output logic          valid
);

  function automatic logic [IW-1:0] wrapIdx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    grantIdx = '0;
    valid    = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[wrapIdx(ptr, i)]) grantIdx = wrapIdx(ptr, i);
    end
    grant = valid ? (N'(1) << grantIdx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/etroc2_link_sync_supervisor.sv
`default_nettype none
// ============================================================================
// Module  : etroc2_link_sync_supervisor
// Brief   : Sequences reset/lock/settle/clear of N ETROC2 frame-sync channels.
// Revision: 1.0 - initial release
// ============================================================================
module etroc2_link_sync_supervisor
  import etroc2_sync_pkg::*;
#(
  parameter int N_LINKS       = 4,
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 40000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3
) (
  input  logic               clk40,
  input  logic               reset,
  input  logic               enable,
  input  logic [N_LINKS-1:0] manualResync,
  input  logic [N_LINKS-1:0] aligned,
  input  logic [N_LINKS-1:0] trigSynched,
  input  logic [N_LINKS-1:0] linkConsistent,
  output logic [N_LINKS-1:0] linkReset,
  output logic [N_LINKS-1:0] clrError,
  output logic [N_LINKS-1:0] linkGood,
  output logic [N_LINKS-1:0] linkFailed,
  output logic               busy,
  output logic [3:0]         activeLink,
  output logic [ATT_W-1:0]   attemptCount
);

  localparam int IW = (N_LINKS > 1) ? $clog2(N_LINKS) : 1;

  syncState_t         r_state, w_stateNext;
  logic [N_LINKS-1:0] r_pending, r_linkReset, r_linkGood, r_linkFailed;
  logic [IW-1:0]      r_active, r_pointer;
  logic [CNT_W-1:0]   r_phaseCnt, r_lockCnt, r_retryCnt;
  logic [ATT_W-1:0]   r_attempts;

  logic [N_LINKS-1:0] w_grantOH, w_activeOH, w_mask, w_good, w_manualSet, w_set;
  logic [IW-1:0]      w_grantIdx, w_nextPtr;
  logic               w_grantValid, w_grantNow, w_retryAgain, w_retryNow, w_failNow;
  logic               w_locked, w_settled, w_phaseDone, w_settleDone, w_timeout;

  rr_arbiter #(.N(N_LINKS), .IW(IW)) u_arb (
    .req      (r_pending),
    .ptr      (r_pointer),
    .grant    (w_grantOH),
    .grantIdx (w_grantIdx),
    .valid    (w_grantValid)
  );

  assign w_activeOH   = N_LINKS'(1) << r_active;
  assign w_good       = aligned & trigSynched & linkConsistent;
  assign w_locked     = aligned[r_active] & trigSynched[r_active];
  assign w_settled    = w_locked & linkConsistent[r_active];
  assign w_phaseDone  = (r_phaseCnt == CNT_W'(RESET_CYCLES - 1));
  assign w_settleDone = (r_phaseCnt == CNT_W'(SETTLE_CYCLES - 1));
  assign w_timeout    = (r_lockCnt == CNT_W'(LOCK_TIMEOUT - 1));
  assign w_retryAgain = ((r_retryCnt + 1'b1) < CNT_W'(MAX_RETRY));
  assign w_grantNow   = (r_state == ST_IDLE) & w_grantValid;
  assign w_retryNow   = (r_state == ST_RETRY) & w_retryAgain;
  assign w_failNow    = (r_state == ST_RETRY) & ~w_retryAgain;
  assign w_nextPtr    = (r_active == IW'(N_LINKS - 1)) ? '0 : r_active + 1'b1;

  // The link being granted or serviced ignores new requests.
  assign w_mask      = (r_state == ST_IDLE) ? (w_grantValid ? w_grantOH : '0) : w_activeOH;
  assign w_manualSet = manualResync & ~w_mask;
  assign w_set       = w_manualSet | ({N_LINKS{enable}} & r_linkGood & ~w_good & ~w_mask);

  always_ff @(posedge clk40 or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:      if (w_grantValid) w_stateNext = ST_RESET;
      ST_RESET:     if (w_phaseDone) w_stateNext = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (w_locked) w_stateNext = ST_SETTLE;
                    else if (w_timeout) w_stateNext = ST_RETRY;
      ST_SETTLE:    if (w_settled && w_settleDone) w_stateNext = ST_CLEAR;
                    else if (w_timeout) w_stateNext = ST_RETRY;
      ST_CLEAR:     w_stateNext = ST_IDLE;
      ST_RETRY:     w_stateNext = w_retryAgain ? ST_RESET : ST_IDLE;
      default:      w_stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != ST_IDLE);
    clrError = (r_state == ST_CLEAR) ? w_activeOH : '0;
  end

  always_ff @(posedge clk40 or negedge reset) begin
    if (!reset) begin
      r_pending    <= '1;
      r_linkReset  <= '0;
      r_linkGood   <= '0;
      r_linkFailed <= '0;
      r_active     <= '0;
      r_pointer    <= '0;
      r_phaseCnt   <= '0;
      r_lockCnt    <= '0;
      r_retryCnt   <= '0;
      r_attempts   <= '0;
    end else begin
      r_pending    <= (r_pending | w_set) & ~(w_grantNow ? w_grantOH : '0);
      r_linkGood   <= (r_linkGood & ~w_set) | ((r_state == ST_CLEAR) ? w_activeOH : '0);
      r_linkFailed <= (r_linkFailed & ~w_manualSet) | (w_failNow ? w_activeOH : '0);

      if (w_grantNow)                          r_linkReset <= r_linkReset & ~w_grantOH;
      else if (w_retryNow)                     r_linkReset <= r_linkReset & ~w_activeOH;
      else if (r_state == ST_RESET && w_phaseDone) r_linkReset <= r_linkReset | w_activeOH;

      if (w_stateNext != r_state)    r_phaseCnt <= '0;
      else if (r_state == ST_RESET)  r_phaseCnt <= r_phaseCnt + 1'b1;
      else if (r_state == ST_SETTLE) r_phaseCnt <= w_settled ? r_phaseCnt + 1'b1 : '0;

      // One budget spans both lock acquisition and the settle window.
      if (r_state == ST_WAIT_LOCK || r_state == ST_SETTLE) r_lockCnt <= r_lockCnt + 1'b1;
      else                                                 r_lockCnt <= '0;

      if (w_grantNow) begin
        r_active   <= w_grantIdx;
        r_retryCnt <= '0;
      end else if (r_state == ST_RETRY) begin
        r_retryCnt <= r_retryCnt + 1'b1;
      end

      if ((w_grantNow || w_retryNow) && r_attempts != '1) r_attempts <= r_attempts + 1'b1;

      if (r_state == ST_CLEAR || w_failNow) r_pointer <= w_nextPtr;
    end
  end

  assign linkReset    = r_linkReset;
  assign linkGood     = r_linkGood;
  assign linkFailed   = r_linkFailed;
  assign activeLink   = 4'(r_active);
  assign attemptCount = r_attempts;

endmodule
`default_nettype wire

// File: tb/tb_etroc2_link_sync_supervisor.sv
`default_nettype none
// ============================================================================
// Module  : tb_etroc2_link_sync_supervisor
// Brief   : Scoreboard bench: expected clrError pulses queued, monitor compares.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_etroc2_link_sync_supervisor;

  localparam int N          = 4;
  localparam int LOCK_DELAY = 5;
  localparam int CLR_OFS    = 1046; // grant edge to CLEAR: 16 + 5 + 1 + 1024
  localparam int SVC        = 1048; // grant-to-grant period of back-to-back service

  logic         clk40 = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic [N-1:0] manualResync = '0;
  logic [N-1:0] aligned, trigSynched, linkConsistent;
  logic [N-1:0] linkReset, clrError, linkGood, linkFailed;
  logic         busy;
  logic [3:0]   activeLink;
  logic [7:0]   attemptCount;

  logic [N-1:0] neverAlign = '0, alignGlitch = '0, consistDrop = '0;
  logic [N-1:0] prevRst = '0;
  int relCnt[N] = '{default: 0};
  int falls[N]  = '{default: 0};
  int lowCnt[N] = '{default: 0};
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {int link; int at;} exp_t;
  exp_t expQ[$];
  exp_t monE;

  etroc2_link_sync_supervisor #(
    .N_LINKS(N), .RESET_CYCLES(16), .LOCK_TIMEOUT(2000), .SETTLE_CYCLES(1024), .MAX_RETRY(3)
  ) dut (
    .clk40(clk40), .reset(reset), .enable(enable), .manualResync(manualResync),
    .aligned(aligned), .trigSynched(trigSynched), .linkConsistent(linkConsistent),
    .linkReset(linkReset), .clrError(clrError), .linkGood(linkGood), .linkFailed(linkFailed),
    .busy(busy), .activeLink(activeLink), .attemptCount(attemptCount)
  );

  always #5 clk40 = ~clk40;
  always @(posedge clk40) cyc <= cyc + 1;

  // Channel model: locks LOCK_DELAY cycles after its reset is released.
  always @(posedge clk40) begin
    for (int i = 0; i < N; i++) begin
      if (!linkReset[i])          relCnt[i] <= 0;
      else if (relCnt[i] < 100000) relCnt[i] <= relCnt[i] + 1;
    end
  end

  always_comb begin
    aligned = '0; trigSynched = '0; linkConsistent = '0;
    for (int i = 0; i < N; i++) begin
      trigSynched[i]    = linkReset[i] && (relCnt[i] >= LOCK_DELAY) && !neverAlign[i];
      aligned[i]        = trigSynched[i] && !alignGlitch[i];
      linkConsistent[i] = trigSynched[i] && !consistDrop[i];
    end
  end

  always @(negedge clk40) begin
    prevRst <= linkReset;
    for (int i = 0; i < N; i++) begin
      if (reset && prevRst[i] && !linkReset[i]) falls[i] <= falls[i] + 1;
      if (reset && !linkReset[i]) lowCnt[i] <= lowCnt[i] + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic pushExp(input int link, input int at);
    exp_t e;
    e.link = link;
    e.at   = at;
    expQ.push_back(e);
  endtask

  // Monitor: every clrError pulse must match the head of the scoreboard.
  always @(negedge clk40) begin
    if (reset && clrError != '0) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL clrError_unexpected actual=0x%0h required=none (cyc %0d)", clrError, cyc);
      end else begin
        monE = expQ.pop_front();
        check("clrError_link", 32'(clrError), 32'(1) << monE.link);
        check("clrError_cycle", cyc, monE.at);
      end
    end
  end

  task automatic waitAllGood(input int budget, input string tag);
    int n;
    n = 0;
    while (!(linkGood == '1 && !busy && expQ.size() == 0) && n < budget) begin
      @(negedge clk40);
      n++;
    end
    check({"done_", tag}, 32'(n < budget), 1);
  endtask

  initial begin
    int g, c, n, snapFalls[N], snapLow[N];

    repeat (3) @(negedge clk40);
    check("rst_linkReset", 32'(linkReset), 0);
    check("rst_clrError", 32'(clrError), 0);
    check("rst_linkGood", 32'(linkGood), 0);
    check("rst_linkFailed", 32'(linkFailed), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_activeLink", 32'(activeLink), 0);
    check("rst_attemptCount", 32'(attemptCount), 0);

    // Power-up: links serviced 0,1,2,3 back to back.
    reset = 1'b1;
    g = cyc + 1;
    for (int k = 0; k < N; k++) pushExp(k, g + k * SVC + CLR_OFS);
    @(negedge clk40);
    check("pu_grant_busy", 32'(busy), 1);
    check("pu_grant_active", 32'(activeLink), 0);
    check("pu_grant_linkReset", 32'(linkReset), 0);
    waitAllGood(6000, "powerup");
    check("pu_linkGood", 32'(linkGood), 'hF);
    check("pu_attempts", 32'(attemptCount), 4);

    // Auto resync of link 2 after a one-cycle consistency drop.
    enable = 1'b1;
    @(negedge clk40);
    for (int i = 0; i < N; i++) begin snapFalls[i] = falls[i]; snapLow[i] = lowCnt[i]; end
    consistDrop[2] = 1'b1;
    g = cyc + 2;
    @(negedge clk40);
    consistDrop[2] = 1'b0;
    check("auto_linkGood_drop", 32'(linkGood), 'b1011);
    pushExp(2, g + CLR_OFS);
    @(negedge clk40);
    check("auto_linkReset", 32'(linkReset), 'b1011);
    check("auto_active", 32'(activeLink), 2);
    waitAllGood(3000, "auto");
    check("auto_low_cycles", lowCnt[2] - snapLow[2], 16);
    check("auto_others_untouched",
          (falls[0] - snapFalls[0]) + (falls[1] - snapFalls[1]) + (falls[3] - snapFalls[3]), 0);
    check("auto_attempts", 32'(attemptCount), 5);

    // Fairness: request all links while link 3 is in service.
    manualResync = 4'b1000;
    g = cyc + 2;
    @(negedge clk40);
    manualResync = '0;
    pushExp(3, g + CLR_OFS);
    for (int k = 0; k < 3; k++) pushExp(k, g + (k + 1) * SVC + CLR_OFS);
    @(negedge clk40);
    check("fair_active", 32'(activeLink), 3);
    repeat (3) @(negedge clk40);
    manualResync = 4'b1111;
    @(negedge clk40);
    manualResync = '0;
    check("fair_linkGood_cleared", 32'(linkGood), 0);
    waitAllGood(6000, "fair");
    check("fair_attempts", 32'(attemptCount), 9);

    // Settle restart: aligned[0] glitches at settle cycle 500.
    manualResync = 4'b0001;
    g = cyc + 2;
    @(negedge clk40);
    manualResync = '0;
    n = 0;
    while (cyc < g + 522 && n < 2000) begin @(negedge clk40); n++; end
    check("settle_reach", 32'(dut.r_state == 3'd3), 1);
    alignGlitch[0] = 1'b1;
    c = cyc;
    @(negedge clk40);
    alignGlitch[0] = 1'b0;
    pushExp(0, c + 1025);
    waitAllGood(3000, "settle");
    check("settle_attempts", 32'(attemptCount), 10);

    // Failure: link 1 never aligns, three timed-out attempts.
    neverAlign[1] = 1'b1;
    snapFalls[1] = falls[1];
    manualResync = 4'b0010;
    @(negedge clk40);
    manualResync = '0;
    n = 0;
    while (!linkFailed[1] && n < 7000) begin @(negedge clk40); n++; end
    check("fail_reached", 32'(n < 7000), 1);
    check("fail_linkFailed", 32'(linkFailed), 'b0010);
    check("fail_linkReset", 32'(linkReset), 'hF);
    check("fail_linkGood", 32'(linkGood), 'b1101);
    check("fail_busy", 32'(busy), 0);
    check("fail_attempts", 32'(attemptCount), 13);
    check("fail_reset_pulses", falls[1] - snapFalls[1], 3);

    // Manual re-arm of the failed link.
    neverAlign[1] = 1'b0;
    manualResync = 4'b0010;
    g = cyc + 2;
    @(negedge clk40);
    manualResync = '0;
    check("rearm_linkFailed", 32'(linkFailed), 0);
    pushExp(1, g + CLR_OFS);
    waitAllGood(3000, "rearm");
    check("rearm_attempts", 32'(attemptCount), 14);

    // Asynchronous reset during WAIT_LOCK of link 2.
    manualResync = 4'b0100;
    @(negedge clk40);
    manualResync = '0;
    n = 0;
    while (!(busy && activeLink == 4'd2 && linkReset[2]) && n < 100) begin @(negedge clk40); n++; end
    check("mid_wait_lock", 32'(n < 100), 1);
    @(negedge clk40);
    #2 reset = 1'b0;
    #1;
    check("mid_linkReset", 32'(linkReset), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_linkGood", 32'(linkGood), 0);
    check("mid_attempts", 32'(attemptCount), 0);
    @(negedge clk40);
    @(negedge clk40);
    reset = 1'b1;
    g = cyc + 1;
    for (int k = 0; k < N; k++) pushExp(k, g + k * SVC + CLR_OFS);
    @(negedge clk40);
    check("mid_restart_active", 32'(activeLink), 0);
    waitAllGood(6000, "restart");
    check("mid_restart_attempts", 32'(attemptCount), 4);
    check("scoreboard_empty", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/etroc2_link_sync_supervisor.md
# etroc2_link_sync_supervisor

Sequences bring-up and re-synchronisation of `N_LINKS` ETROC2 data-frame-sync channels that share one resync procedure. It owns each channel's active-low reset and `clrError` strobe. It monitors `aligned`/`trigSynched`/`linkConsistent`, and it arbitrates manual and automatic resync requests round-robin. It sits between the slow-control register block and the per-channel frame-sync instances.

## Interface
- `N_LINKS`, 4: number of supervised channels (1–16).
- `RESET_CYCLES`, 16: `linkReset` low time, in cycles.
- `LOCK_TIMEOUT`, 40000: maximum wait for `aligned & trigSynched`, in cycles (1 ms).
- `SETTLE_CYCLES`, 1024: required continuous-good window.
- `MAX_RETRY`, 3: number of timed-out attempts before a link is declared failed.

Ports:
- `clk40` in 1: 40 MHz clock.
- `reset` in 1: asynchronous, active-low.
- `enable` in 1: enables automatic resync on loss of lock.
- `manualResync` in N_LINKS: per-link request pulses.
- `aligned`, `trigSynched`, `linkConsistent` in N_LINKS: channel status.
- `linkReset` out N_LINKS: active-low reset to each channel.
- `clrError` out N_LINKS: one-cycle error-clear strobe.
- `linkGood` out N_LINKS: link locked and settled.
- `linkFailed` out N_LINKS: retries exhausted.
- `busy` out 1: FSM not IDLE.
- `activeLink` out 4: index under service.
- `attemptCount` out 8: total attempts started, saturates at 255.

## Operation
- Reset values:
  - `linkReset` all 0 (every link held in reset).
  - `pending` all 1.
  - `clrError`, `linkGood`, `linkFailed`, `busy` and `attemptCount` are 0.
  - `activeLink` is 0 and the round-robin pointer is 0.
- Pending set sources:
  - A `manualResync[i]` pulse also clears `linkFailed[i]`.
  - Auto: `enable & linkGood[i] & ~(aligned[i] & trigSynched[i] & linkConsistent[i])`.
  - Setting `pending[i]` clears `linkGood[i]`.
- The active link is masked from both set sources: requests for it while `busy` are dropped.
- FSM states:
  - IDLE: if any bit is pending, grant the lowest index at or above the pointer, with wrap. Clear `pending[g]`, set `activeLink=g`, set the retry counter to 0, increment `attemptCount`, go to RESET.
  - RESET: `linkReset[g]=0` for `RESET_CYCLES`, then release `linkReset[g]=1` and go to WAIT_LOCK.
  - WAIT_LOCK: once `aligned[g] & trigSynched[g]`, go to SETTLE. At `LOCK_TIMEOUT` cycles, go to RETRY.
  - SETTLE: requires `aligned & trigSynched & linkConsistent` for `SETTLE_CYCLES` consecutive cycles, then go to CLEAR.
    - A drop during SETTLE restarts the window.
    - Total time in WAIT_LOCK+SETTLE is bounded by `LOCK_TIMEOUT`; on expiry, go to RETRY.
  - CLEAR: `clrError[g]=1` for one cycle, set `linkGood[g]`, set pointer to g+1 mod N_LINKS, go to IDLE.
  - RETRY: increment the retry counter.
    - If it is below `MAX_RETRY`: increment `attemptCount` and go to RESET.
    - Otherwise: set `linkFailed[g]`, leave `linkReset[g]=1`, advance the pointer, go to IDLE.
- A failed link is excluded from auto requests (`linkGood=0`). Only `manualResync` re-arms it.
- Counters are 16-bit and unsigned. The timeout and settle compares use equality with `PARAM-1`.

## Timing
- Grant latency: a pending bit in IDLE leads to `linkReset[g]` going low on the next edge. `busy` rises on the same edge.
- `manualResync` and the auto condition are registered: the pending bit is visible one cycle after the input.
- Best-case service time, from grant to `linkGood`: `RESET_CYCLES + 1 + SETTLE_CYCLES + 1` cycles.
- A same-cycle set and grant on the granted link results in the grant; the request is dropped.
- Asynchronous `reset` mid-service returns all outputs to their reset values immediately. All links are then re-queued.
- `clrError` is never asserted for more than one cycle, and never for a non-active link.

## Structure
- Shared package `etroc2_sync_pkg`:
  - FSM state encoding (IDLE, RESET, WAIT_LOCK, SETTLE, CLEAR, RETRY).
  - Counter width constant (16).
  - `attemptCount` width (8).
- Sub-module `rr_arbiter`, parameterised by N: inputs are the request vector and the pointer. Outputs are a one-hot grant, an encoded index and a valid flag. It is purely combinational.

## Test plan
- **Power-up:** reset released, all four links lock 5 cycles after `linkReset` release → links serviced in order 0,1,2,3. Each gets exactly one `clrError` pulse. `linkGood`=4'hF and `attemptCount`=4.
- **Auto resync:** all good, `enable`=1, drop `linkConsistent[2]` for 1 cycle → `linkGood[2]` falls next cycle. `linkReset[2]` is low for 16 cycles. Other links are untouched.
- **Failure:** link 1 never aligns → 3 attempts of 16+40000 cycles each. Then `linkFailed[1]`=1, `linkReset[1]`=1 and `attemptCount` increases by 3. Pulsing `manualResync[1]` clears `linkFailed[1]` and retries.
- **Settle restart:** `aligned[0]` glitches low at settle cycle 500 → the window restarts. `clrError[0]` fires 1024 cycles after the glitch recovers.
- **Fairness:** `manualResync`=4'b1111 while link 3 is being serviced → the pulse on link 3 is dropped. Service order after link 3 is 0,1,2.
- **Mid-service reset:** assert `reset` during WAIT_LOCK of link 2 → asynchronously `linkReset`=0, `busy`=0 and `linkGood`=0. After release, service restarts at link 0.
